// File: rtl/rr_xbar_if.sv
// Bundle of the rr_xbar master-side (req/gnt/resp) and slave-side (req/gnt/rdata) buses.
// Latency: none, wires only.
// Backpressure: carries gnt_i/gnt_o; the modports fix the direction of each signal.
interface rr_xbar_if #(
   parameter int NumIn         = 4,
   parameter int NumOut        = 4,
   parameter int ReqDataWidth  = 32,
   parameter int RespDataWidth = 32
);
   localparam int AddrW = $clog2(NumOut);
   localparam int IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1;

   logic [NumIn-1:0]                     req_i;
   logic [NumIn-1:0][AddrW-1:0]          add_i;
   logic [NumIn-1:0]                     wen_i;
   logic [NumIn-1:0][ReqDataWidth-1:0]   wdata_i;
   logic [NumIn-1:0]                     gnt_o;
   logic [NumIn-1:0]                     vld_o;
   logic [NumIn-1:0][RespDataWidth-1:0]  rdata_o;
   logic [NumOut-1:0][IdxW-1:0]          rr_i;
   logic [NumOut-1:0]                    req_o;
   logic [NumOut-1:0]                    gnt_i;
   logic [NumOut-1:0][ReqDataWidth-1:0]  wdata_o;
   logic [NumOut-1:0][RespDataWidth-1:0] rdata_i;

   // Environment side: drives master requests and slave grants/responses.
   modport master (
      output req_i, add_i, wen_i, wdata_i, rr_i, gnt_i, rdata_i,
      input  gnt_o, vld_o, rdata_o, req_o, wdata_o
   );

   // Crossbar side.
   modport slave (
      input  req_i, add_i, wen_i, wdata_i, rr_i, gnt_i, rdata_i,
      output gnt_o, vld_o, rdata_o, req_o, wdata_o
   );
endinterface

// File: rtl/rr_xbar.sv
// NumIn x NumOut request/grant crossbar, round-robin per output; optional checks under XBAR_ASSERT_EN.
// Latency: grant combinational, response/vld_o exactly RespLat cycles after grant.
// Backpressure: gnt_i low on an output stalls only that output's winner; req_o never depends on gnt_i.
module rr_xbar #(
   parameter int NumIn         = 4,
   parameter int NumOut        = 4,
   parameter int ReqDataWidth  = 32,
   parameter int RespDataWidth = 32,
   parameter int RespLat       = 1,
   parameter bit WriteRespOn   = 1'b1,
   parameter bit ExtPrio       = 1'b0
) (
   input logic       clk_i,
   input logic       rst_ni,
   rr_xbar_if.slave  bus
);
   localparam int AddrW = $clog2(NumOut);
   localparam int IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1;

   logic [NumIn-1:0][NumOut-1:0] req_dec;
   logic [NumOut-1:0][IdxW-1:0]  start;
   logic [NumOut-1:0][IdxW-1:0]  win;
   logic [NumOut-1:0]            req_out;
   logic [NumIn-1:0]             gnt;

   always_comb begin
      req_dec = '0;
      for (int i = 0; i < NumIn; i++) begin
         if (bus.req_i[i]) req_dec[i][bus.add_i[i]] = 1'b1;
      end
   end

   // Cyclic scan from the start index; with no requester win stays at start.
   always_comb begin
      logic found;
      int   idx;
      found   = 1'b0;
      idx     = 0;
      win     = '0;
      req_out = '0;
      for (int j = 0; j < NumOut; j++) begin
         found  = 1'b0;
         win[j] = IdxW'(int'(start[j]) % NumIn);
         for (int k = 0; k < NumIn; k++) begin
            idx = (int'(start[j]) + k) % NumIn;
            if (!found && req_dec[idx][j]) begin
               found  = 1'b1;
               win[j] = IdxW'(idx);
            end
         end
         req_out[j] = found;
      end
   end

   always_comb begin
      gnt = '0;
      for (int i = 0; i < NumIn; i++) begin
         gnt[i] = bus.req_i[i] && (win[bus.add_i[i]] == IdxW'(i)) && bus.gnt_i[bus.add_i[i]];
      end
   end

   assign bus.req_o = req_out;
   assign bus.gnt_o = gnt;

   for (genvar j = 0; j < NumOut; j++) begin : g_wdata
      assign bus.wdata_o[j] = bus.wdata_i[win[j]];
   end

   if (ExtPrio) begin : g_ext
      assign start = bus.rr_i;
   end else begin : g_ptr
      logic [NumOut-1:0][IdxW-1:0] ptr_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ptr_q <= '0;
         end else begin
            for (int j = 0; j < NumOut; j++) begin
               if (req_out[j] && bus.gnt_i[j]) ptr_q[j] <= IdxW'((int'(win[j]) + 1) % NumIn);
            end
         end
      end
      assign start = ptr_q;
   end

   // Stage 0 holds the last granted index so idle masters keep a stable rdata mux.
   logic [NumIn-1:0][RespLat-1:0][AddrW-1:0] idx_q;
   logic [NumIn-1:0][RespLat-1:0]            vld_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
         vld_q <= '0;
      end else begin
         for (int i = 0; i < NumIn; i++) begin
            vld_q[i][0] <= gnt[i] && (!bus.wen_i[i] || WriteRespOn);
            if (gnt[i]) idx_q[i][0] <= bus.add_i[i];
            for (int s = 1; s < RespLat; s++) begin
               vld_q[i][s] <= vld_q[i][s-1];
               idx_q[i][s] <= idx_q[i][s-1];
            end
         end
      end
   end

   for (genvar i = 0; i < NumIn; i++) begin : g_resp
      assign bus.vld_o[i]   = vld_q[i][RespLat-1];
      assign bus.rdata_o[i] = bus.rdata_i[idx_q[i][RespLat-1]];
   end

`ifdef XBAR_ASSERT_EN
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert ((NumOut & (NumOut - 1)) == 0) else $fatal(1, "rr_xbar: NumOut not a power of 2");
         assert (RespLat >= 1) else $fatal(1, "rr_xbar: RespLat < 1");
         for (int j = 0; j < NumOut; j++) begin
            logic [NumIn-1:0] gmask;
            gmask = '0;
            for (int i = 0; i < NumIn; i++) gmask[i] = gnt[i] && (int'(bus.add_i[i]) == j);
            assert ($onehot0(gmask)) else $fatal(1, "rr_xbar: multiple grants on output %0d", j);
         end
         for (int i = 0; i < NumIn; i++) begin
            if (gnt[i]) begin
               assert (bus.req_i[i]) else $fatal(1, "rr_xbar: grant without request on %0d", i);
               assert (req_out[bus.add_i[i]]) else $fatal(1, "rr_xbar: grant without req_o on %0d", i);
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_rr_xbar.sv
// Directed bench for rr_xbar: default config, ExtPrio=1 config, and WriteRespOn=0/RespLat=2 config.
module tb_rr_xbar;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rr_xbar_if #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32)) ifa ();
   rr_xbar_if #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32)) ifb ();
   rr_xbar_if #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32)) ifc ();

   rr_xbar #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
             .RespLat(1), .WriteRespOn(1'b1), .ExtPrio(1'b0))
      u_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
   rr_xbar #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
             .RespLat(1), .WriteRespOn(1'b1), .ExtPrio(1'b1))
      u_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));
   rr_xbar #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
             .RespLat(2), .WriteRespOn(1'b0), .ExtPrio(1'b0))
      u_c (.clk_i(clk), .rst_ni(rst_n), .bus(ifc));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ifa.req_i = '0; ifa.add_i = '0; ifa.wen_i = '0; ifa.wdata_i = '0;
      ifa.rr_i  = '0; ifa.gnt_i = '0; ifa.rdata_i = '0;
      ifb.req_i = '0; ifb.add_i = '0; ifb.wen_i = '0; ifb.wdata_i = '0;
      ifb.rr_i  = '0; ifb.gnt_i = '0; ifb.rdata_i = '0;
      ifc.req_i = '0; ifc.add_i = '0; ifc.wen_i = '0; ifc.wdata_i = '0;
      ifc.rr_i  = '0; ifc.gnt_i = '0; ifc.rdata_i = '0;
      ifa.rdata_i[0] = 32'hA5A5A5A5;
      ifc.rdata_i[0] = 32'hA5A5A5A5;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_vld_a", ifa.vld_o, 4'h0);
      check("rst_req_o_a", ifa.req_o, 4'h0);
      check("rst_vld_c", ifc.vld_o, 4'h0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_rdata_a%0d", i), ifa.rdata_o[i], 32'hA5A5A5A5);
         check($sformatf("rst_rdata_c%0d", i), ifc.rdata_o[i], 32'hA5A5A5A5);
      end
      rst_n = 1'b1;
      step();

      // Contention: all masters read output 2
      for (int i = 0; i < 4; i++) begin
         ifa.add_i[i]   = 2'd2;
         ifa.wdata_i[i] = 32'h200 + i;
      end
      ifa.rdata_i[2] = 32'h102;
      ifa.req_i = 4'hF;
      ifa.gnt_i = 4'hF;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("cont_gnt%0d", k), ifa.gnt_o, 4'b0001 << (k % 4));
         check($sformatf("cont_wdata%0d", k), ifa.wdata_o[2], 32'h200 + (k % 4));
         check($sformatf("cont_req_o%0d", k), ifa.req_o, 4'b0100);
         step();
         check($sformatf("cont_vld%0d", k), ifa.vld_o, 4'b0001 << (k % 4));
         check($sformatf("cont_rdata%0d", k), ifa.rdata_o[k % 4], 32'h102);
      end
      ifa.req_i = '0;

      // Disjoint traffic: master i reads output 3-i
      for (int i = 0; i < 4; i++) begin
         ifa.add_i[i]   = 2'(3 - i);
         ifa.rdata_i[i] = 32'h100 + i;
      end
      ifa.req_i = 4'hF;
      ifa.gnt_i = 4'b1011;
      #1;
      check("disj_gnt_partial", ifa.gnt_o, 4'b1101);
      check("disj_req_o_partial", ifa.req_o, 4'hF);
      ifa.gnt_i = 4'hF;
      #1;
      check("disj_gnt", ifa.gnt_o, 4'hF);
      step();
      ifa.req_i = '0;
      check("disj_vld", ifa.vld_o, 4'hF);
      for (int i = 0; i < 4; i++)
         check($sformatf("disj_rdata%0d", i), ifa.rdata_o[i], 32'h100 + (3 - i));
      step();
      check("disj_vld_drop", ifa.vld_o, 4'h0);

      // Backpressure: master 1 on output 0, gnt_i[0] low for 3 cycles
      ifa.add_i[1] = 2'd0;
      ifa.req_i    = 4'b0010;
      ifa.gnt_i    = 4'b1110;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_req_o%0d", k), ifa.req_o, 4'b0001);
         check($sformatf("bp_gnt%0d", k), ifa.gnt_o, 4'b0000);
         step();
         check($sformatf("bp_vld%0d", k), ifa.vld_o, 4'b0000);
      end
      ifa.gnt_i = 4'hF;
      #1;
      check("bp_gnt_rise", ifa.gnt_o, 4'b0010);
      step();
      check("bp_vld", ifa.vld_o, 4'b0010);
      check("bp_rdata", ifa.rdata_o[1], 32'h100);
      // Pointer for output 0 now sits at master 2
      ifa.add_i[0] = 2'd0;
      ifa.add_i[3] = 2'd0;
      ifa.req_i    = 4'b1011;
      #1;
      check("bp_ptr_next", ifa.gnt_o, 4'b1000);
      step();
      ifa.req_i = '0;

      // External priority
      ifb.add_i[0] = 2'd1;
      ifb.add_i[3] = 2'd1;
      ifb.req_i    = 4'b1001;
      ifb.gnt_i    = 4'hF;
      ifb.rr_i[1]  = 2'd2;
      #1;
      check("ext_rr2", ifb.gnt_o, 4'b1000);
      check("ext_req_o", ifb.req_o, 4'b0010);
      ifb.rr_i[1] = 2'd0;
      #1;
      check("ext_rr0", ifb.gnt_o, 4'b0001);
      ifb.rr_i[1] = 2'd1;
      #1;
      check("ext_rr1", ifb.gnt_o, 4'b1000);
      ifb.req_i = '0;

      // WriteRespOn=0, RespLat=2: write then read from master 0
      ifc.rdata_i[1] = 32'h101;
      ifc.rdata_i[3] = 32'h103;
      ifc.gnt_i      = 4'hF;
      ifc.add_i[0]   = 2'd3;
      ifc.wen_i[0]   = 1'b1;
      ifc.req_i      = 4'b0001;
      #1;
      check("wr_gnt", ifc.gnt_o, 4'b0001);
      step();
      ifc.add_i[0] = 2'd1;
      ifc.wen_i[0] = 1'b0;
      #1;
      check("rd_gnt", ifc.gnt_o, 4'b0001);
      step();
      ifc.req_i = '0;
      check("wr_no_vld", ifc.vld_o, 4'b0000);
      step();
      check("rd_vld", ifc.vld_o, 4'b0001);
      check("rd_rdata", ifc.rdata_o[0], 32'h101);
      step();
      check("rd_vld_drop", ifc.vld_o, 4'b0000);

      // Reset mid-flight drops the pending response
      ifc.add_i[2] = 2'd3;
      ifc.req_i    = 4'b0100;
      #1;
      check("mid_gnt", ifc.gnt_o, 4'b0100);
      step();
      ifc.req_i = '0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      step();
      check("mid_vld1", ifc.vld_o, 4'b0000);
      step();
      check("mid_vld2", ifc.vld_o, 4'b0000);
      check("mid_rdata", ifc.rdata_o[2], 32'hA5A5A5A5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
